dcache_miss_ctrl: RTL
=====================

# dcache_miss_ctrl

Direct-mapped, write-back, write-allocate data cache with its miss-handling state machine, sitting in the MEM stage of the RISC-V pipeline. It is the producer of `DCacheMiss`, the stall request consumed by the hazard unit. While a miss is serviced it holds `DCacheMiss` high so the pipeline freezes. It moves whole lines to and from main memory over a word-serial request/grant port.

## Interface
- `SETS`, 64: number of lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rd_req` input 1: load access in MEM stage.
- `wr_req` input 1: store access. If `rd_req` and `wr_req` are both high, the access is treated as a store.
- `addr` input 32: byte address, word-aligned. Fields: offset [1:0] ignored; word [W+1:2]; index [I+W+1:W+2]; tag is the remaining upper bits. W = log2(LINE_WORDS), I = log2(SETS).
- `wr_data` input 32: store data.
- `wr_be` input 4: store byte enables.
- `rd_data` output 32: load data, combinational on hit.
- `DCacheMiss` output 1: stall request to the hazard unit.
- `mem_rd_req` output 1: memory word read request.
- `mem_wr_req` output 1: memory word write request.
- `mem_addr` output 32: word address of the current transfer; bits [1:0] = 0.
- `mem_wr_data` output 32: write-back word.
- `mem_rd_data` input 32: refill word, valid when `mem_gnt` is high during a read.
- `mem_gnt` input 1: current word accepted or returned this cycle.

## Operation
- Per-line state: valid bit, dirty bit, tag, and LINE_WORDS data words. Valid and dirty are reset; tag and data are not.
- Hit: `(rd_req|wr_req)` && state==IDLE && valid[index] && tag match.
  - Load hit: `rd_data` = the addressed word in the same cycle.
  - Store hit: the bytes selected by `wr_be` are written at the clock edge, and dirty[index] is set.
- `DCacheMiss` = `(rd_req|wr_req) && !hit` while in IDLE, or state != IDLE.
- FSM states: IDLE, WB, REFILL, DONE.
  - IDLE: on a miss, latch index and tag. Go to WB if the victim is valid and dirty, otherwise go to REFILL. The word counter is cleared.
  - WB: `mem_wr_req`=1, `mem_addr` = {victim tag, index, cnt, 2'b00}, `mem_wr_data` = victim word[cnt]. On `mem_gnt`, cnt increments. After the last word, go to REFILL with cnt=0.
  - REFILL: `mem_rd_req`=1, `mem_addr` = {new tag, index, cnt, 2'b00}. On `mem_gnt`, write `mem_rd_data` into word[cnt] and increment cnt. On the last word, set the new tag, valid=1, dirty=0, and go to DONE.
  - DONE: one cycle, then go to IDLE. The held request then re-evaluates as a hit; a store then merges and sets dirty.
- Memory transfers are never aborted. If the CPU request drops mid-miss, the FSM still completes to DONE.
- `mem_gnt` is ignored when neither memory request is active.

## Timing
- Reset values: FSM=IDLE; cnt=0; all valid and dirty bits=0; `mem_rd_req`=`mem_wr_req`=0; `mem_addr`=0; `mem_wr_data`=0; `DCacheMiss`=0 while no request is present; `rd_data`=0 while no request is present; stats counters=0.
- Hit latency is 0 cycles, and `DCacheMiss` stays low.
- Miss latency with `mem_gnt` high every cycle:
  - Clean victim: `DCacheMiss` is high for LINE_WORDS+2 cycles.
  - Dirty victim: `DCacheMiss` is high for 2·LINE_WORDS+2 cycles.
  - Every cycle with `mem_gnt` low adds one cycle, with `mem_addr` and `mem_wr_data` held stable.
- cnt is W bits wide and wraps to 0 after the last word.
- Reset asserted mid-WB or mid-REFILL: outputs go to their reset values immediately. The partial line stays invalid.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` and `miss_cnt`, each 32 bits and saturating.
  - `miss_cnt` increments on each IDLE→WB or IDLE→REFILL transition.
  - `hit_cnt` increments on each IDLE cycle with a hit, including the retry after DONE.
- Undefined: neither the ports nor the counters exist.

## Structure
- The shared package holds the FSM state enum (IDLE, WB, REFILL, DONE) and the address-field width constants derived from SETS and LINE_WORDS.
- One sub-module, `dcache_line_store`, holds the tag, valid, dirty, and data arrays. It provides an asynchronous read and a byte-enabled synchronous write.

## Test plan
- Cold load from 0x0000_0100, memory returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `mem_gnt` high every cycle:
  - `mem_addr` steps 0x100, 0x104, 0x108, 0x10C.
  - `DCacheMiss` is high for 6 cycles.
  - Then `rd_data`=0x11111111.
- Store to 0x104 with `wr_be`=4'b0001 and `wr_data`=0x000000AA:
  - `DCacheMiss` stays low.
  - A following load of 0x104 returns 0x222222AA.
- Load from 0x0000_0500 (same index, new tag):
  - Write-back goes to 0x100 through 0x10C, including 0x222222AA.
  - Refill follows from 0x500.
  - `DCacheMiss` is high for 10 cycles.
- Refill with `mem_gnt` held low for 3 cycles after word 1:
  - `mem_addr` holds at 0x104.
  - `DCacheMiss` is high for 9 cycles.
- `rst_n` pulsed low during REFILL word 2:
  - `mem_rd_req` drops asynchronously.
  - A reload of 0x100 misses again.
- With `DCACHE_STATS_EN`, after scenarios 1 through 3: `miss_cnt`=2 and `hit_cnt`=4.

Source files
------------

// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and address-field widths for the data-cache miss controller.
package dcache_miss_ctrl_pkg;

   // Miss-handling state machine states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WB     = 2'd1,
      ST_REFILL = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Default geometry: 64 lines of 4 words.
   localparam int DEF_SETS       = 64;
   localparam int DEF_LINE_WORDS = 4;

   // Address fields: [1:0] byte offset, then word, index, tag.
   localparam int DEF_WORD_BITS  = $clog2(DEF_LINE_WORDS);
   localparam int DEF_INDEX_BITS = $clog2(DEF_SETS);
   localparam int DEF_TAG_BITS   = 32 - DEF_INDEX_BITS - DEF_WORD_BITS - 2;

   // Tag width left over once the offset, word and index fields are removed.
   function automatic int tag_bits(int sets, int line_words);
      return 32 - $clog2(sets) - $clog2(line_words) - 2;
   endfunction

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Word-serial memory port between the data cache and main memory.
//
// Handshake: the cache offers one word transfer by raising mem_rd_req or
// mem_wr_req (never both) with mem_addr and, for writes, mem_wr_data
// stable. The transfer completes in the cycle mem_gnt is high; for reads,
// mem_rd_data is valid in that same cycle. While mem_gnt is low the cache
// holds the request, address and data unchanged. mem_gnt in a cycle with
// no request is ignored.
interface dcache_miss_ctrl_if;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;
   logic        mem_gnt;

   modport master (
      output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
      input  mem_rd_data, mem_gnt
   );

   modport slave (
      input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
      output mem_rd_data, mem_gnt
   );
endinterface

// File: rtl/dcache_line_store.sv
// Line storage: valid/dirty bits (reset), tags and data words (not reset).
// One shared index/word selects both the asynchronous read and the write.
module dcache_line_store #(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 22,
   parameter int IW         = $clog2(SETS),
   parameter int WW         = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IW-1:0]    index,
   input  logic [WW-1:0]    word,
   output logic             valid,
   output logic             dirty,
   output logic [TAG_W-1:0] tag,
   output logic [31:0]      rdata,
   input  logic             wr_en,
   input  logic [3:0]       wr_be,
   input  logic [31:0]      wr_data,
   input  logic             set_dirty,
   input  logic             fill,
   input  logic [TAG_W-1:0] fill_tag
);

   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  dirty_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS][LINE_WORDS];

   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign tag   = tag_q[index];
   assign rdata = data_q[index][word];

   // Line status: a completed refill validates a clean line; a store hit dirties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (set_dirty) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Byte-enabled data write and tag update on refill completion.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) data_q[index][word][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
      if (fill) tag_q[index] <= fill_tag;
   end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped write-back, write-allocate data cache with miss FSM.
// Raises DCacheMiss to freeze the pipeline while a line is written back
// and/or refilled over the word-serial memory port.
// Optional feature macro: DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt.
module dcache_miss_ctrl
   import dcache_miss_ctrl_pkg::*;
#(
   parameter int SETS       = DEF_SETS,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_req,
   input  logic               wr_req,
   input  logic [31:0]        addr,
   input  logic [31:0]        wr_data,
   input  logic [3:0]         wr_be,
   output logic [31:0]        rd_data,
   output logic               DCacheMiss,
   dcache_miss_ctrl_if.master mem,
   output state_t             fsm_state
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        miss_cnt
`endif
);

   localparam int W = $clog2(LINE_WORDS);
   localparam int I = $clog2(SETS);
   localparam int T = tag_bits(SETS, LINE_WORDS);

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [I-1:0]   miss_index_q, miss_index_d;
   logic [T-1:0]   miss_tag_q, miss_tag_d;

   logic [W-1:0]   addr_word;
   logic [I-1:0]   addr_index;
   logic [T-1:0]   addr_tag;
   logic           unused_offset;

   logic           access;
   logic           hit;
   logic           last_word;
   logic [I-1:0]   ls_index;
   logic [W-1:0]   ls_word;
   logic           line_valid, line_dirty;
   logic [T-1:0]   line_tag;
   logic [31:0]    line_word;

   logic           st_wr_en;
   logic [3:0]     st_wr_be;
   logic [31:0]    st_wr_data;
   logic           st_set_dirty;
   logic           st_fill;

   assign addr_word     = addr[W+1:2];
   assign addr_index    = addr[I+W+1:W+2];
   assign addr_tag      = addr[31:I+W+2];
   assign unused_offset = ^addr[1:0];

   assign access    = rd_req | wr_req;
   assign last_word = (cnt_q == W'(LINE_WORDS - 1));

   // In IDLE the store is addressed by the CPU; during a miss by the latched line and counter.
   assign ls_index = (state_q == ST_IDLE) ? addr_index : miss_index_q;
   assign ls_word  = (state_q == ST_IDLE) ? addr_word  : cnt_q;

   assign hit        = access && (state_q == ST_IDLE) && line_valid && (line_tag == addr_tag);
   assign DCacheMiss = (state_q != ST_IDLE) || (access && !hit);
   assign rd_data    = hit ? line_word : 32'h0;
   assign fsm_state  = state_q;

   dcache_line_store #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (T),
      .IW         (I),
      .WW         (W)
   ) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .index     (ls_index),
      .word      (ls_word),
      .valid     (line_valid),
      .dirty     (line_dirty),
      .tag       (line_tag),
      .rdata     (line_word),
      .wr_en     (st_wr_en),
      .wr_be     (st_wr_be),
      .wr_data   (st_wr_data),
      .set_dirty (st_set_dirty),
      .fill      (st_fill),
      .fill_tag  (miss_tag_q)
   );

   // Next-state, memory-port drive and line-store write controls.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      miss_index_d    = miss_index_q;
      miss_tag_d      = miss_tag_q;
      mem.mem_rd_req  = 1'b0;
      mem.mem_wr_req  = 1'b0;
      mem.mem_addr    = 32'h0;
      mem.mem_wr_data = 32'h0;
      st_wr_en        = 1'b0;
      st_wr_be        = 4'h0;
      st_wr_data      = 32'h0;
      st_set_dirty    = 1'b0;
      st_fill         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit && wr_req) begin
               st_wr_en     = 1'b1;
               st_wr_be     = wr_be;
               st_wr_data   = wr_data;
               st_set_dirty = 1'b1;
            end else if (access && !hit) begin
               miss_index_d = addr_index;
               miss_tag_d   = addr_tag;
               cnt_d        = '0;
               state_d      = (line_valid && line_dirty) ? ST_WB : ST_REFILL;
            end
         end
         ST_WB: begin
            // Victim tag is still in the array until the refill completes.
            mem.mem_wr_req  = 1'b1;
            mem.mem_addr    = {line_tag, miss_index_q, cnt_q, 2'b00};
            mem.mem_wr_data = line_word;
            if (mem.mem_gnt) begin
               cnt_d = cnt_q + W'(1);
               if (last_word) state_d = ST_REFILL;
            end
         end
         ST_REFILL: begin
            mem.mem_rd_req = 1'b1;
            mem.mem_addr   = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
            if (mem.mem_gnt) begin
               st_wr_en   = 1'b1;
               st_wr_be   = 4'hF;
               st_wr_data = mem.mem_rd_data;
               cnt_d      = cnt_q + W'(1);
               if (last_word) begin
                  st_fill = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, word counter and latched miss address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         miss_index_q <= '0;
         miss_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         miss_index_q <= miss_index_d;
         miss_tag_q   <= miss_tag_d;
      end
   end

`ifdef DCACHE_STATS_EN
   // Saturating hit/miss statistics; a miss is counted when IDLE leaves for WB or REFILL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= 32'h0;
         miss_cnt <= 32'h0;
      end else begin
         if (hit && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'h1;
         if ((state_q == ST_IDLE) && access && !hit && (miss_cnt != 32'hFFFF_FFFF))
            miss_cnt <= miss_cnt + 32'h1;
      end
   end
`endif

endmodule
